// File: rtl/bju_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bju_redirect_ctrl
// Function : Converts BJU resolutions into a registered frontend redirect and
//            buffers BPU training updates in a small FIFO.
// Revision : 1.0
// ============================================================================
module bju_redirect_ctrl #(
    parameter int ROB_DEPTH = 32,
    parameter int UPD_DEPTH = 4,
    localparam int RW = $clog2(ROB_DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          bju_valid,
    output logic          bju_ready,
    input  logic [31:0]   bju_pc,
    input  logic [31:0]   bju_target,
    input  logic          bju_mispredict,
    input  logic          bju_taken,
    input  logic [2:0]    bju_cf,
    input  logic [RW-1:0] bju_rob_idx,
    input  logic [RW-1:0] rob_head,
    input  logic          commit_valid,
    input  logic [RW-1:0] commit_rob_idx,
    input  logic          exc_flush,
    output logic          redirect_valid,
    output logic [31:0]   redirect_pc,
    output logic [RW-1:0] redirect_rob_idx,
    output logic          upd_valid,
    input  logic          upd_ready,
    output logic [31:0]   upd_pc,
    output logic [31:0]   upd_target,
    output logic          upd_taken,
    output logic [2:0]    upd_cf
);

    localparam int         c_PW      = $clog2(UPD_DEPTH);
    localparam int         c_CW      = c_PW + 1;
    localparam logic [2:0] c_CF_NONE = 3'd0;
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_KILL = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [RW-1:0] r_kill_tag;
    logic [RW-1:0] w_kill_tag_nxt;

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic [31:0] r_pc_mem    [UPD_DEPTH];
    logic [31:0] r_tgt_mem   [UPD_DEPTH];
    logic        r_taken_mem [UPD_DEPTH];
    logic [2:0]  r_cf_mem    [UPD_DEPTH];

    logic          w_accept;
    logic          w_drop;
    logic          w_fire;
    logic          w_enq;
    logic          w_deq;
    logic          w_full;
    logic [RW-1:0] w_age_bju;
    logic [RW-1:0] w_age_kill;

    // Ages are distances from the ROB head; RW-bit subtraction gives the modulo.
    assign w_age_bju  = bju_rob_idx - rob_head;
    assign w_age_kill = r_kill_tag - rob_head;

    assign upd_valid  = (r_count != '0);
    assign w_deq      = upd_valid && upd_ready;
    assign w_full     = (r_count == c_CW'(UPD_DEPTH));
    assign bju_ready  = !w_full || w_deq;
    assign w_accept   = bju_valid && bju_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_kill_tag <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_kill_tag <= w_kill_tag_nxt;
        end
    end

    // Next-state logic: a flush wins over everything, a newer redirect over a commit
    always_comb begin
        w_state_nxt    = r_state;
        w_kill_tag_nxt = r_kill_tag;
        if (exc_flush) begin
            w_state_nxt = c_ST_IDLE;
        end else if (w_fire) begin
            w_state_nxt    = c_ST_KILL;
            w_kill_tag_nxt = bju_rob_idx;
        end else if ((r_state == c_ST_KILL) && commit_valid &&
                     (commit_rob_idx == r_kill_tag)) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    // Output decode
    always_comb begin
        w_drop = w_accept && (r_state == c_ST_KILL) && (w_age_bju > w_age_kill);
        w_fire = w_accept && !w_drop && bju_mispredict && !exc_flush &&
                 ((r_state == c_ST_IDLE) || (w_age_bju < w_age_kill));
        w_enq  = w_accept && !w_drop && (bju_cf != c_CF_NONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            redirect_rob_idx <= '0;
        end else begin
            redirect_valid <= w_fire;
            if (w_fire) begin
                redirect_pc      <= bju_target;
                redirect_rob_idx <= bju_rob_idx;
            end
        end
    end

    // Storage needs no reset: entries are only visible below r_count.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_pc_mem[r_wr_ptr]    <= bju_pc;
            r_tgt_mem[r_wr_ptr]   <= bju_target;
            r_taken_mem[r_wr_ptr] <= bju_taken;
            r_cf_mem[r_wr_ptr]    <= bju_cf;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + c_CW'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    assign upd_pc     = r_pc_mem[r_rd_ptr];
    assign upd_target = r_tgt_mem[r_rd_ptr];
    assign upd_taken  = r_taken_mem[r_rd_ptr];
    assign upd_cf     = r_cf_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_bju_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bju_redirect_ctrl
// Function : Scoreboard bench for bju_redirect_ctrl with directed and random
//            stimulus against an age-arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_bju_redirect_ctrl;

    localparam int         ROB_DEPTH   = 32;
    localparam int         UPD_DEPTH   = 4;
    localparam logic [2:0] c_CF_NONE   = 3'd0;
    localparam logic [2:0] c_CF_BRANCH = 3'd1;
    localparam logic [2:0] c_CF_JAL    = 3'd2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        bju_valid = 1'b0;
    logic        bju_ready;
    logic [31:0] bju_pc = '0;
    logic [31:0] bju_target = '0;
    logic        bju_mispredict = 1'b0;
    logic        bju_taken = 1'b0;
    logic [2:0]  bju_cf = '0;
    logic [4:0]  bju_rob_idx = '0;
    logic [4:0]  rob_head = '0;
    logic        commit_valid = 1'b0;
    logic [4:0]  commit_rob_idx = '0;
    logic        exc_flush = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [4:0]  redirect_rob_idx;
    logic        upd_valid;
    logic        upd_ready = 1'b0;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [2:0]  upd_cf;

    bju_redirect_ctrl #(.ROB_DEPTH(ROB_DEPTH), .UPD_DEPTH(UPD_DEPTH)) dut (
        .clock(clock), .reset(reset),
        .bju_valid(bju_valid), .bju_ready(bju_ready),
        .bju_pc(bju_pc), .bju_target(bju_target),
        .bju_mispredict(bju_mispredict), .bju_taken(bju_taken),
        .bju_cf(bju_cf), .bju_rob_idx(bju_rob_idx), .rob_head(rob_head),
        .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
        .exc_flush(exc_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_rob_idx(redirect_rob_idx),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_cf(upd_cf)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] pc;
        logic [4:0]  idx;
    } redir_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [2:0]  cf;
    } upd_t;

    redir_t      redir_q[$];
    upd_t        upd_q[$];
    redir_t      mon_r;
    logic [31:0] cyc = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model: FIFO occupancy plus an optional outstanding kill tag
    int mdl_cnt = 0;
    bit mdl_kill = 1'b0;
    int mdl_tag = 0;
    bit clear_upd_q = 1'b0;

    always @(posedge clock) cyc <= cyc + 32'd1;

    function automatic int age(input int x, input int h);
        return ((x - h) % ROB_DEPTH + ROB_DEPTH) % ROB_DEPTH;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic mis, input logic tk, input logic [2:0] cf,
                        input logic [4:0] idx, input logic [4:0] head,
                        input logic cv, input logic [4:0] cidx, input logic exc,
                        input logic ur, input logic rst);
        bit exp_ready, acc, drop, fire, enq, deq;
        int a_new, a_kill;
        @(posedge clock);
        if (clear_upd_q) begin
            upd_q.delete();
            clear_upd_q = 1'b0;
        end
        #2;
        bju_valid = v; bju_pc = pc; bju_target = tgt; bju_mispredict = mis;
        bju_taken = tk; bju_cf = cf; bju_rob_idx = idx; rob_head = head;
        commit_valid = cv; commit_rob_idx = cidx; exc_flush = exc;
        upd_ready = ur; reset = rst;
        #1;
        exp_ready = (mdl_cnt < UPD_DEPTH) || (mdl_cnt > 0 && ur);
        check("bju_ready", 32'(bju_ready), 32'(exp_ready));
        check("upd_valid", 32'(upd_valid), 32'(mdl_cnt != 0));
        a_new  = age(int'(idx), int'(head));
        a_kill = age(mdl_tag, int'(head));
        acc  = v && exp_ready;
        drop = acc && mdl_kill && (a_new > a_kill);
        fire = acc && !drop && mis && !exc && (!mdl_kill || a_new < a_kill);
        enq  = acc && !drop && (cf != c_CF_NONE);
        deq  = (mdl_cnt > 0) && ur;
        if (rst) begin
            mdl_cnt = 0; mdl_kill = 1'b0; mdl_tag = 0; clear_upd_q = 1'b1;
        end else begin
            if (fire) redir_q.push_back(redir_t'{cyc: cyc + 32'd1, pc: tgt, idx: idx});
            if (enq) upd_q.push_back(upd_t'{pc: pc, target: tgt, taken: tk, cf: cf});
            mdl_cnt = mdl_cnt + int'(enq) - int'(deq);
            if (exc) begin
                mdl_kill = 1'b0;
            end else if (fire) begin
                mdl_kill = 1'b1;
                mdl_tag  = int'(idx);
            end else if (mdl_kill && cv && int'(cidx) == mdl_tag) begin
                mdl_kill = 1'b0;
            end
        end
    endtask

    task automatic res(input logic [31:0] pc, input logic [31:0] tgt, input logic mis,
                       input logic tk, input logic [2:0] cf, input logic [4:0] idx,
                       input logic [4:0] head, input logic exc, input logic ur);
        step(1'b1, pc, tgt, mis, tk, cf, idx, head, 1'b0, 5'd0, exc, ur, 1'b0);
    endtask

    task automatic idle(input logic [4:0] head, input logic ur);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, c_CF_NONE, 5'd0, head, 1'b0, 5'd0, 1'b0, ur, 1'b0);
    endtask

    task automatic commit(input logic [4:0] head, input logic [4:0] cidx, input logic ur);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, c_CF_NONE, 5'd0, head, 1'b1, cidx, 1'b0, ur, 1'b0);
    endtask

    // Monitor: pops expected responses whenever the DUT presents one
    always @(negedge clock) begin
        if (redirect_valid) begin
            if (redir_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL redirect_unexpected: got pc %h idx %0d, expected no redirect (cycle %0d)",
                         redirect_pc, redirect_rob_idx, cyc);
            end else begin
                mon_r = redir_q.pop_front();
                check("redirect_cycle", cyc, mon_r.cyc);
                check("redirect_pc", redirect_pc, mon_r.pc);
                check("redirect_rob_idx", 32'(redirect_rob_idx), 32'(mon_r.idx));
            end
        end else if (redir_q.size() != 0 && redir_q[0].cyc <= cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL redirect_missing: got none, expected pc %h idx %0d (cycle %0d)",
                     redir_q[0].pc, redir_q[0].idx, cyc);
            void'(redir_q.pop_front());
        end
        if (upd_valid) begin
            if (upd_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL upd_unexpected: got pc %h, expected empty FIFO (cycle %0d)", upd_pc, cyc);
            end else begin
                check("upd_pc", upd_pc, upd_q[0].pc);
                check("upd_target", upd_target, upd_q[0].target);
                check("upd_taken", 32'(upd_taken), 32'(upd_q[0].taken));
                check("upd_cf", 32'(upd_cf), 32'(upd_q[0].cf));
                if (upd_ready) void'(upd_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic        v, mis, tk, cv, exc, ur;
        logic [2:0]  cf;
        logic [4:0]  idx, head, cidx;
        logic [31:0] pc, tgt;

        repeat (3) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, c_CF_NONE, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Single mispredict, then a wrong-path drop and commit of the branch
        res(32'h8000_0010, 32'h8000_0100, 1'b1, 1'b1, c_CF_BRANCH, 5'd5, 5'd0, 1'b0, 1'b0);
        idle(5'd0, 1'b0);
        res(32'h8000_0020, 32'h8000_0300, 1'b1, 1'b1, c_CF_BRANCH, 5'd7, 5'd0, 1'b0, 1'b0);
        idle(5'd0, 1'b0);
        commit(5'd0, 5'd5, 1'b1);
        idle(5'd0, 1'b1);

        // Older override across the ROB wrap point
        res(32'h8000_0030, 32'h8000_0180, 1'b1, 1'b0, c_CF_BRANCH, 5'd2, 5'd30, 1'b0, 1'b1);
        res(32'h8000_0040, 32'h8000_0200, 1'b1, 1'b1, c_CF_BRANCH, 5'd31, 5'd30, 1'b0, 1'b1);
        res(32'h8000_0050, 32'h8000_0400, 1'b1, 1'b1, c_CF_BRANCH, 5'd0, 5'd30, 1'b0, 1'b1);
        commit(5'd30, 5'd31, 1'b1);
        idle(5'd30, 1'b1);

        // FIFO full back-pressure and same-cycle enqueue/dequeue
        for (int i = 0; i < 4; i++)
            res(32'h9000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i * 16), 1'b0, 1'b1,
                c_CF_JAL, 5'(i), 5'd0, 1'b0, 1'b0);
        idle(5'd0, 1'b0);
        res(32'h9000_0100, 32'hA000_0100, 1'b0, 1'b1, c_CF_JAL, 5'd4, 5'd0, 1'b0, 1'b1);
        res(32'h9000_0200, 32'hA000_0200, 1'b0, 1'b1, c_CF_JAL, 5'd5, 5'd0, 1'b0, 1'b0);
        repeat (5) idle(5'd0, 1'b1);

        // Exception flush beats a same-cycle older mispredict
        res(32'h8100_0000, 32'h8100_0100, 1'b1, 1'b1, c_CF_BRANCH, 5'd8, 5'd0, 1'b0, 1'b0);
        res(32'h8100_0010, 32'h8100_0110, 1'b0, 1'b0, c_CF_BRANCH, 5'd6, 5'd0, 1'b0, 1'b0);
        res(32'h8100_0020, 32'h8100_0120, 1'b1, 1'b1, c_CF_NONE, 5'd3, 5'd0, 1'b1, 1'b0);
        res(32'h8100_0030, 32'h8100_0130, 1'b1, 1'b0, c_CF_BRANCH, 5'd12, 5'd0, 1'b0, 1'b0);
        idle(5'd0, 1'b0);
        repeat (4) idle(5'd0, 1'b1);
        commit(5'd0, 5'd12, 1'b1);

        // Reset in the cycle after an accepted mispredict with two entries queued
        res(32'h8200_0000, 32'h8200_0100, 1'b0, 1'b1, c_CF_BRANCH, 5'd1, 5'd0, 1'b0, 1'b0);
        res(32'h8200_0010, 32'h8200_0110, 1'b1, 1'b1, c_CF_BRANCH, 5'd4, 5'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, c_CF_NONE, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle(5'd0, 1'b0);
        res(32'h8200_0020, 32'h8200_0120, 1'b1, 1'b0, c_CF_JAL, 5'd9, 5'd0, 1'b0, 1'b1);
        idle(5'd0, 1'b1);
        commit(5'd0, 5'd9, 1'b1);

        // Randomized traffic
        head = 5'd0;
        for (int n = 0; n < 400; n++) begin
            v    = ($urandom_range(0, 99) < 60);
            mis  = ($urandom_range(0, 3) == 0);
            tk   = 1'($urandom_range(0, 1));
            cf   = 3'($urandom_range(0, 3));
            idx  = 5'($urandom_range(0, 31));
            pc   = $urandom;
            tgt  = $urandom;
            if ($urandom_range(0, 15) == 0) head = 5'($urandom_range(0, 31));
            if (mdl_kill && int'(idx) == mdl_tag) idx = idx + 5'd1;
            exc  = ($urandom_range(0, 29) == 0);
            if (exc) cf = c_CF_NONE;
            cv   = !v && ($urandom_range(0, 3) == 0);
            cidx = ($urandom_range(0, 1) == 0) ? 5'(mdl_tag) : 5'($urandom_range(0, 31));
            ur   = 1'($urandom_range(0, 1));
            step(v, pc, tgt, mis, tk, cf, idx, head, cv, cidx, exc, ur, 1'b0);
        end

        repeat (8) idle(head, 1'b1);
        check("upd_queue_drained", 32'(upd_q.size()), 32'd0);
        check("redirect_queue_drained", 32'(redir_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bju_redirect_ctrl.md
Name: bju_redirect_ctrl

Overview:
- Sits between the BJU write-back stage, the frontend and the BPU.
- Turns BJU resolutions into a one-cycle registered frontend redirect and backend flush.
- Suppresses wrong-path resolutions younger than an outstanding redirect.
- Buffers BPU training updates in a small FIFO with a valid/ready handshake; back-pressures the BJU when that FIFO is full.

Parameters:
- ROB_DEPTH, 32, ROB entries; power of 2; index width RW = log2(ROB_DEPTH).
- UPD_DEPTH, 4, BPU update FIFO entries; power of 2, at least 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bju_valid  in  1  resolution valid (bju.valid)
- bju_ready  out  1  block can accept a resolution this cycle
- bju_pc  in  32  branch PC
- bju_target  in  32  resolved target address
- bju_mispredict  in  1  resolution mispredicted
- bju_taken  in  1  conditional branch taken
- bju_cf  in  3  control-flow type, OoO_pkg encoding; CF_NONE = 0
- bju_rob_idx  in  RW  ROB index of the branch
- rob_head  in  RW  ROB index of the oldest in-flight instruction
- commit_valid  in  1  an instruction commits this cycle
- commit_rob_idx  in  RW  ROB index of the committing instruction
- exc_flush  in  1  exception/trap flush
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  32  redirect target
- redirect_rob_idx  out  RW  mispredicting branch; backend kills entries younger than it
- upd_valid  out  1  BPU update available
- upd_ready  in  1  BPU accepts the update
- upd_pc, upd_target  out  32 each  FIFO head fields
- upd_taken  out  1  FIFO head field
- upd_cf  out  3  FIFO head field

Behaviour:
- Age: age(x) = (x - rob_head) mod ROB_DEPTH. A is older than B iff age(A) < age(B).
- Accept: a resolution is accepted when bju_valid && bju_ready.
- Drop: an accepted resolution is dropped when the state is KILL and age(bju_rob_idx) > age(kill_tag). A dropped resolution generates nothing; it is still consumed.
- States:
  - IDLE: no outstanding redirect.
  - KILL: redirect outstanding; kill_tag holds the ROB index of that branch.
- IDLE -> KILL: accepted, not-dropped resolution with bju_mispredict=1. Load kill_tag = bju_rob_idx.
- KILL -> KILL with a new kill_tag: accepted mispredict with age(bju_rob_idx) < age(kill_tag). It re-redirects.
- KILL -> IDLE:
  - commit_valid && commit_rob_idx == kill_tag, or
  - exc_flush.
- Precedence: exc_flush has priority over a same-cycle mispredict. The mispredict is discarded and no redirect is issued.
- Redirect timing: registered, exactly 1 cycle after acceptance. In that cycle redirect_valid=1, redirect_pc=bju_target, redirect_rob_idx=bju_rob_idx. Otherwise redirect_valid=0.
- Training FIFO:
  - Every accepted, not-dropped resolution with bju_cf != CF_NONE enqueues {pc, target, taken, cf}. This includes correctly predicted ones.
  - Dequeue when upd_valid && upd_ready.
  - Same-cycle enqueue and dequeue keeps the count unchanged; allowed while full.
  - Pointers wrap mod UPD_DEPTH.
  - The upd_* outputs show the head entry combinationally from the registers. upd_valid = (count != 0).
  - exc_flush does not clear the FIFO.
- bju_ready = !(count == UPD_DEPTH) || (upd_valid && upd_ready).
- Reset values: state=IDLE, kill_tag=0, count=0, pointers=0, redirect_valid=0, redirect_pc=0, redirect_rob_idx=0, upd_valid=0. bju_ready=1 from the first cycle after reset.
- Reset mid-operation: a pending redirect pulse is cancelled, the FIFO is emptied, and the state returns to IDLE.

Test Plan:
- Single mispredict:
  - Stimulus: rob_head=0; bju mispredict, pc=0x8000_0010, target=0x8000_0100, rob_idx=5, cf=BRANCH, taken=1.
  - Response: next cycle redirect_valid=1, redirect_pc=0x8000_0100, redirect_rob_idx=5; upd_valid=1 with the same fields.
- Wrong-path drop:
  - Stimulus: after the previous case (kill_tag=5), resolution rob_idx=7 mispredict.
  - Response: no redirect, no FIFO entry, bju_ready stays 1.
  - Follow-up: commit_rob_idx=5 returns the state to IDLE.
- Older override with wrap:
  - Stimulus: rob_head=30, kill_tag=2; mispredict rob_idx=31, target=0x8000_0200.
  - Response: redirect to 0x8000_0200, kill_tag=31.
  - Follow-up: a later rob_idx=0 resolution is dropped.
- FIFO full back-pressure:
  - Stimulus: upd_ready=0; 4 correct-predicted JAL resolutions.
  - Response: count=4, bju_ready=0.
  - Follow-up: upd_ready=1 makes bju_ready=1 in the same cycle; a concurrent enqueue keeps count=4. Draining yields entries in FIFO order.
- Exception precedence:
  - Stimulus: exc_flush=1 in the same cycle as a mispredict rob_idx=3.
  - Response: no redirect_valid, state=IDLE, FIFO contents preserved.
- Reset mid-operation:
  - Stimulus: assert reset in the cycle after a mispredict is accepted, with count=2.
  - Response: redirect_valid=0, upd_valid=0, state=IDLE.
